// File: rtl/pool_window_buffer_pkg.sv
// rtl/pool_window_buffer_pkg.sv - shared pixel width and window-former state encoding
package pool_window_buffer_pkg;

  localparam int PIX_W = 10;

  typedef enum logic [1:0] {
    PW_IDLE = 2'd0,
    PW_FILL = 2'd1,
    PW_EMIT = 2'd2
  } pw_state_t;

endpackage

// File: rtl/pool_window_buffer_line_ram.sv
// rtl/pool_window_buffer_line_ram.sv - single-port synchronous line RAM, no-change read during write
module pool_line_ram #(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 10,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/pool_window_buffer.sv
// rtl/pool_window_buffer.sv - streaming 2x2 window former feeding the max-pool stage
module pool_window_buffer
  import pool_window_buffer_pkg::*;
#(
  parameter  int DATA_W = PIX_W,
  parameter  int IMG_W  = 640,
  parameter  int IMG_H  = 480,
  localparam int XW     = $clog2(IMG_W / 2),
  localparam int YW     = $clog2(IMG_H / 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_in,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [DATA_W-1:0] d3,
  output logic [DATA_W-1:0] d4,
  output logic              win_valid,
  output logic [XW-1:0]     win_x,
  output logic [YW-1:0]     win_y,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  pw_state_t state, state_n;
  logic [CW-1:0] col, col_eff, col_n, col_next, ram_addr;
  logic [RW-1:0] row, row_eff, row_n;
  logic fs, accept, ram_we, emit, last, latch_left;
  logic [DATA_W-1:0] ram_rdata, top_left, cur_left, row0_left;

  always_comb begin
    fs       = pix_valid & frame_start;
    accept   = pix_valid & (fs | (state != PW_IDLE));
    col_eff  = fs ? '0 : col;
    row_eff  = fs ? '0 : row;
    col_n    = (col_eff == COL_LAST) ? '0 : col_eff + CW'(1);
    row_n    = row_eff;
    if (col_eff == COL_LAST) row_n = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
    col_next = accept ? col_n : col;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= PW_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (accept) state_n = row_n[0] ? PW_EMIT : PW_FILL;
  end

  // Odd rows keep the RAM pointed at the upcoming column, so the word for the
  // accepted pixel is already on rdata. Column 0 follows a write cycle at the
  // row wrap, so its top-left comes from a dedicated register instead.
  always_comb begin
    ram_we     = accept & ~row_eff[0];
    latch_left = accept & row_eff[0] & ~col_eff[0];
    emit       = accept & row_eff[0] & col_eff[0];
    last       = emit & (row_eff == ROW_LAST) & (col_eff == COL_LAST);
    ram_addr   = ram_we ? col_eff : col_next;
  end

  pool_line_ram #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (pix_in),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      d4         <= '0;
      win_x      <= '0;
      win_y      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      top_left   <= '0;
      cur_left   <= '0;
      row0_left  <= '0;
    end else begin
      win_valid  <= emit;
      frame_done <= last;
      if (accept) begin
        col <= col_n;
        row <= row_n;
      end
      if (ram_we && col_eff == '0) row0_left <= pix_in;
      if (latch_left) begin
        cur_left <= pix_in;
        top_left <= (col_eff == '0) ? row0_left : ram_rdata;
      end
      if (emit) begin
        d1    <= top_left;
        d2    <= ram_rdata;
        d3    <= cur_left;
        d4    <= pix_in;
        win_x <= col_eff[CW-1:1];
        win_y <= row_eff[RW-1:1];
      end
    end
  end

endmodule

// File: doc/pool_window_buffer.md
# pool_window_buffer

Streaming 2×2 window former for the 2×2 max-pooling path. It accepts one 10-bit pixel per valid cycle in raster order, stores even rows in a single line RAM, and on every odd-row/odd-column pixel presents the four pixels of the completed 2×2 block on `d1..d4`. These outputs feed the combinational four-input maximum stage directly downstream.

## Interface

Parameters:
- `DATA_W`, 10: pixel width.
- `IMG_W`, 640: pixels per line. Must be even and ≥ 2.
- `IMG_H`, 480: lines per frame. Must be even and ≥ 2.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset. Synchronous and active-low.
- `frame_start`, in, 1: marks the first pixel of a frame. Sampled only when `pix_valid`=1.
- `pix_valid`, in, 1: `pix_in` is valid this cycle. There is no backpressure.
- `pix_in`, in, DATA_W: pixel value.
- `d1`, out, DATA_W: top-left pixel of the window.
- `d2`, out, DATA_W: top-right pixel of the window.
- `d3`, out, DATA_W: bottom-left pixel of the window.
- `d4`, out, DATA_W: bottom-right pixel of the window.
- `win_valid`, out, 1: one-cycle pulse. `d1..d4`, `win_x` and `win_y` are valid.
- `win_x`, out, $clog2(IMG_W/2): window column, equal to col/2.
- `win_y`, out, $clog2(IMG_H/2): window row, equal to row/2.
- `frame_done`, out, 1: one-cycle pulse together with the last window of a frame.

## Operation

Counters:
- `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1.
- Both advance only on accepted pixels (`pix_valid`=1).
- `col` wraps to 0 at IMG_W-1 and increments `row`.
- `row` wraps to 0 at IMG_H-1.

`frame_start`:
- A valid pixel with `frame_start`=1 is treated as col=0, row=0, whatever the counter values.
- Counters then continue from col=1.
- A partial frame in progress is abandoned: no window and no `frame_done` for the unfinished block.

Even rows:
- `pix_in` is written to line RAM address `col`.
- No output is produced.

Odd rows:
- Line RAM address `col` is read. This returns the pixel from the row above at the same column.
- Even col: latch `pix_in` into `cur_left` and the RAM word into `top_left`.
- Odd col: set `d1`=top_left, `d2`=RAM word, `d3`=cur_left, `d4`=pix_in, and pulse `win_valid`.

`frame_done`:
- Pulses with the window at row=IMG_H-1, col=IMG_W-1.

States (2-bit FSM, for documentation and coverage):
- IDLE: after reset, waiting for the first valid `frame_start`. Valid pixels without `frame_start` are ignored.
- FILL: even row in progress.
- EMIT: odd row in progress.
- FILL↔EMIT switches at each column wrap.
- EMIT→FILL at the frame end, ready for the next frame.

Line RAM:
- IMG_W×DATA_W, single port.
- Writes only on even rows and reads only on odd rows, so no read/write collision can occur.
- Contents are not cleared by reset. Every location is rewritten before it is read.

## Timing

- Latency: `win_valid` is asserted the cycle after the clock edge that accepts the odd-row/odd-col pixel. The bottom-right pixel is therefore registered one cycle.
- The line RAM read is synchronous, 1 cycle. Address is driven from the next-pixel path, or the pipeline is aligned, so that `d2` and `top_left` match this 1-cycle latency.
- `d1..d4`, `win_x` and `win_y` hold their last values between pulses.
- Throughput: at most one window per two accepted odd-row pixels. Gaps in `pix_valid` of any length are allowed anywhere, including across lines and frames.
- Reset values: `d1..d4`=0, `win_valid`=0, `frame_done`=0, `win_x`=0, `win_y`=0, FSM=IDLE, counters=0.
- Reset mid-frame: the next cycle shows all outputs at their reset values and no pending window is emitted. Operation resumes only at the next `frame_start`.
- `frame_start` coincident with the final pixel of the previous frame: the new frame wins. That pixel becomes (0,0) and the pending window is dropped.

## Structure

- Shared package: `PIX_W`=10 and the FSM state encoding (`PW_IDLE`, `PW_FILL`, `PW_EMIT`), shared with the pooling and max stages.
- One sub-module: `pool_line_ram`, a single-port synchronous RAM parameterised by depth and width, inferrable as block RAM.
- Counters, FSM and window registers stay in the top module.

## Test plan

All scenarios use IMG_W=4, IMG_H=4.

- **Ramp frame:** after `frame_start`, stream pixels 0..15 back-to-back. Expect 4 windows:
  - (0,0): d={0,1,4,5}
  - (1,0): d={2,3,6,7}
  - (0,1): d={8,9,12,13}
  - (1,1): d={10,11,14,15}, with `frame_done`.
- **Random `pix_valid` gaps:** same ramp with 0–3 idle cycles between pixels. Expect identical windows, each `win_valid` exactly 1 cycle after its d4 pixel.
- **Reset mid-frame:** drive `rst_n`=0 after pixel 6, then hold it high.
  - Expect outputs at their reset values and no window.
  - A fresh frame of 100..115 yields first window {100,101,104,105}.
- **Re-sync:** `frame_start` asserted on pixel 9 of the current frame. Expect that pixel treated as (0,0) and the next windows computed from the new frame only.
- **Pixels before first `frame_start`:** send 5 pixels with no `frame_start`. Expect no `win_valid`, then normal output once the frame starts.
- **Extremes:** all pixels 10'h3FF. Expect every `d` = 10'h3FF, 4 windows, and exactly 1 `frame_done`.
